// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared state type, default sizes and depth helper for the register file
package reg_file_pkg;
  typedef enum logic {IDLE, CLEARING} state_t;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 3;
  localparam int DEF_NUM_RD = 2;
  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction
endpackage

// File: rtl/reg_file_rd_port.sv
// reg_file_rd_port: one combinational read lane with clear mask, zero register and write bypass
module reg_file_rd_port #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int BYPASS = 1,
  parameter int ZERO_R0 = 0
) (
  input  logic [(2**ADDR_W)*DATA_W-1:0] regs_flat,
  input  logic [ADDR_W-1:0]             rd_addr,
  input  logic [DATA_W-1:0]             wr_data,
  input  logic [ADDR_W-1:0]             wr_addr,
  input  logic                          wr_en,
  input  logic                          clr_busy,
  output logic [DATA_W-1:0]             data
);
  always_comb
    data = clr_busy ? '0 :
           (ZERO_R0 != 0 && rd_addr == '0) ? '0 :
           (BYPASS != 0 && wr_en && rd_addr == wr_addr) ? wr_data :
           regs_flat[int'(rd_addr)*DATA_W +: DATA_W];
endmodule

// File: rtl/reg_file_param.sv
// reg_file_param: parametrised register file with sequenced clear, write stall, bypass and optional zero register
module reg_file_param
  import reg_file_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = DEF_NUM_RD,
  parameter int BYPASS = 1,
  parameter int ZERO_R0 = 0
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic [DATA_W-1:0]        IN,
  input  logic [ADDR_W-1:0]        INADDRESS,
  input  logic                     WRITE,
  input  logic                     BUSYWAIT,
  input  logic [NUM_RD*ADDR_W-1:0] RDADDR,
  output logic [NUM_RD*DATA_W-1:0] OUT,
  output logic                     CLR_BUSY
);
  localparam int DEPTH = depth_of(ADDR_W);
  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH*DATA_W-1:0] regs_flat;
  state_t state, state_nxt;
  logic [ADDR_W:0] clr_idx, clr_idx_nxt;
  logic wr_en;
  assign CLR_BUSY = state == CLEARING;
  assign wr_en = state == IDLE && WRITE && !BUSYWAIT && !(ZERO_R0 != 0 && INADDRESS == '0);
  always_comb begin
    state_nxt = state;
    clr_idx_nxt = clr_idx;
    if (state == CLEARING) begin
      clr_idx_nxt = clr_idx + 1'b1;
      state_nxt = (clr_idx == (ADDR_W+1)'(DEPTH-1)) ? IDLE : CLEARING;
    end
  end
  always_ff @(posedge CLK)
    if (RESET) begin
      state <= CLEARING;
      clr_idx <= '0;
    end else begin
      state <= state_nxt;
      clr_idx <= clr_idx_nxt;
    end
  always_ff @(posedge CLK)
    if (state == CLEARING) regs[clr_idx[ADDR_W-1:0]] <= '0;
    else if (wr_en) regs[INADDRESS] <= IN;
  for (genvar i = 0; i < DEPTH; i++) begin : g_flat
    assign regs_flat[i*DATA_W +: DATA_W] = regs[i];
  end
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    reg_file_rd_port #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS), .ZERO_R0(ZERO_R0)
    ) u_rd (
      .regs_flat(regs_flat),
      .rd_addr(RDADDR[k*ADDR_W +: ADDR_W]),
      .wr_data(IN),
      .wr_addr(INADDRESS),
      .wr_en(wr_en),
      .clr_busy(CLR_BUSY),
      .data(OUT[k*DATA_W +: DATA_W])
    );
  end
endmodule

// File: tb/tb_reg_file_param.sv
// tb_reg_file_param: directed checks of clear, write, stall, bypass and zero-register behaviour
module tb_reg_file_param;
  logic       CLK = 0;
  logic       RESET = 0;
  logic [7:0] IN = 0;
  logic [2:0] INADDRESS = 0;
  logic       WRITE = 0;
  logic       BUSYWAIT = 0;
  logic [5:0] RDADDR = 0;
  logic [15:0] out_b, out_nb, out_z;
  logic busy_b, busy_nb, busy_z;
  int checks = 0;
  int errors = 0;
  always #5 CLK = ~CLK;
  reg_file_param #(.BYPASS(1), .ZERO_R0(0)) dut (
    .CLK(CLK), .RESET(RESET), .IN(IN), .INADDRESS(INADDRESS), .WRITE(WRITE),
    .BUSYWAIT(BUSYWAIT), .RDADDR(RDADDR), .OUT(out_b), .CLR_BUSY(busy_b));
  reg_file_param #(.BYPASS(0), .ZERO_R0(0)) dut_nb (
    .CLK(CLK), .RESET(RESET), .IN(IN), .INADDRESS(INADDRESS), .WRITE(WRITE),
    .BUSYWAIT(BUSYWAIT), .RDADDR(RDADDR), .OUT(out_nb), .CLR_BUSY(busy_nb));
  reg_file_param #(.BYPASS(1), .ZERO_R0(1)) dut_z (
    .CLK(CLK), .RESET(RESET), .IN(IN), .INADDRESS(INADDRESS), .WRITE(WRITE),
    .BUSYWAIT(BUSYWAIT), .RDADDR(RDADDR), .OUT(out_z), .CLR_BUSY(busy_z));
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge CLK);
    #1;
  endtask
  initial begin
    RESET = 1;
    step();
    RESET = 0;
    for (int i = 0; i < 8; i++) begin
      chk("clr_busy", {13'd0, busy_b, busy_nb, busy_z}, 16'h0007);
      chk("clr_out", out_b | out_nb | out_z, 16'h0000);
      step();
    end
    chk("clr_done", {13'd0, busy_b, busy_nb, busy_z}, 16'h0000);
    for (int i = 0; i < 8; i++) begin
      RDADDR = {3'(i), 3'(i)};
      #1;
      chk("clr_regs", out_b | out_nb | out_z, 16'h0000);
    end
    WRITE = 1; INADDRESS = 3; IN = 8'hA5;
    step();
    INADDRESS = 6; IN = 8'h3C;
    step();
    WRITE = 0;
    RDADDR = {3'd6, 3'd3};
    #1;
    chk("wr_rd", out_b, 16'h3CA5);
    chk("wr_rd_nb", out_nb, 16'h3CA5);
    chk("wr_rd_z", out_z, 16'h3CA5);
    RDADDR = {3'd3, 3'd3};
    #1;
    chk("same_addr", out_b, 16'hA5A5);
    WRITE = 1; INADDRESS = 2; IN = 8'h77; BUSYWAIT = 1; RDADDR = {3'd2, 3'd2};
    #1;
    chk("stall_byp_off", out_b, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_hold", out_b, 16'h0000);
      chk("stall_hold_nb", out_nb, 16'h0000);
    end
    BUSYWAIT = 0;
    #1;
    chk("stall_release_nb", out_nb, 16'h0000);
    step();
    WRITE = 0;
    #1;
    chk("stall_commit", out_b, 16'h7777);
    chk("stall_commit_nb", out_nb, 16'h7777);
    WRITE = 1; INADDRESS = 5; IN = 8'h11;
    step();
    IN = 8'h99; RDADDR = {3'd0, 3'd5};
    #1;
    chk("bypass_pre", out_b[7:0], 16'h0099);
    chk("nobypass_pre", out_nb[7:0], 16'h0011);
    step();
    WRITE = 0;
    #1;
    chk("bypass_post", out_b[7:0], 16'h0099);
    chk("nobypass_post", out_nb[7:0], 16'h0099);
    WRITE = 1; INADDRESS = 0; IN = 8'hFF; RDADDR = {3'd0, 3'd0};
    #1;
    chk("zero_pre", out_z, 16'h0000);
    chk("nozero_byp", out_b, 16'hFFFF);
    step();
    WRITE = 0;
    #1;
    chk("zero_post", out_z, 16'h0000);
    chk("nozero_post", out_nb, 16'hFFFF);
    RESET = 1;
    step();
    RESET = 0;
    for (int i = 0; i < 4; i++) step();
    chk("mid_busy", {15'd0, busy_b}, 16'h0001);
    RESET = 1; WRITE = 1; INADDRESS = 3; IN = 8'hEE; RDADDR = {3'd3, 3'd3};
    step();
    RESET = 0;
    for (int i = 0; i < 8; i++) begin
      chk("restart_busy", {13'd0, busy_b, busy_nb, busy_z}, 16'h0007);
      chk("restart_out", out_b | out_nb | out_z, 16'h0000);
      step();
    end
    chk("restart_done", {13'd0, busy_b, busy_nb, busy_z}, 16'h0000);
    WRITE = 0;
    #1;
    chk("clr_write_dropped", out_b | out_nb, 16'h0000);
    RDADDR = {3'd6, 3'd5};
    #1;
    chk("reclr_regs", out_b | out_nb, 16'h0000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
